// File: rtl/icache_responder.sv
// ---------------------------------------------------------------------------
// icache_responder
//
// Instruction-side responder for the core fetch port. A direct-mapped,
// read-only cache of instruction lines answers fetches combinationally on a
// hit. On a miss it requests the whole line from backing memory and writes the
// returned beats in ascending word order. While a refill is in progress the
// core sees ready low.
//
// Optional build macro: ICACHE_PERF_COUNTERS_EN adds hit/miss counters.
//
// Ports:
//   clk_i                  clock
//   rst_ni                 asynchronous active-low reset
//   icache_read_address_i  fetch byte address (bits [1:0] ignored)
//   icache_read_valid_i    core requests a fetch this cycle
//   icache_read_data_o     instruction word, valid while ready is high
//   icache_read_ready_o    hit: data valid this cycle
//   flush_i                invalidate all lines (fence.i)
//   mem_req_valid_o        line refill request
//   mem_req_ready_i        memory accepts the request
//   mem_req_address_o      line-aligned refill address
//   mem_resp_valid_i       one refill beat present
//   mem_resp_data_i        refill beat data
//   hit_count_o            (macro only) cycles with ready high
//   miss_count_o           (macro only) refills started
// ---------------------------------------------------------------------------
module icache_responder #(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] icache_read_address_i,
  input  logic        icache_read_valid_i,
  output logic [31:0] icache_read_data_o,
  output logic        icache_read_ready_o,
  input  logic        flush_i,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_req_address_o,
  input  logic        mem_resp_valid_i,
`ifdef ICACHE_PERF_COUNTERS_EN
  output logic [31:0] hit_count_o,
  output logic [31:0] miss_count_o,
`endif
  input  logic [31:0] mem_resp_data_i
);

  localparam int IDX_W = $clog2(LINES);
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int TAG_W = 30 - IDX_W - OFF_W;
  localparam int LA_W  = 30 - OFF_W;   // line address width (tag + index)

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    REFILL = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Storage: only the valid bits carry reset; data and tags are qualified by them.
  logic [31:0]      data_q [LINES*WORDS_PER_LINE];
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [LINES-1:0] valid_q;

  logic [LA_W-1:0]  miss_line_q;
  logic [OFF_W-1:0] cnt_q;
  logic             flushed_q;

  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             hit;

  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;

  logic             miss_start;
  logic             beat_we;
  logic             line_done;

  logic             unused_addr_bits;

  assign unused_addr_bits = ^icache_read_address_i[1:0];

  // Combinational lookup
  assign req_off = icache_read_address_i[OFF_W+1:2];
  assign req_idx = icache_read_address_i[OFF_W+IDX_W+1:OFF_W+2];
  assign req_tag = icache_read_address_i[31:OFF_W+IDX_W+2];
  assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  assign fill_idx = miss_line_q[IDX_W-1:0];
  assign fill_tag = miss_line_q[LA_W-1:IDX_W];

  // Gating on the valid bit keeps data at zero until something is cached there.
  assign icache_read_data_o = valid_q[req_idx] ? data_q[{req_idx, req_off}] : '0;
  assign mem_req_address_o  = {miss_line_q, {(OFF_W+2){1'b0}}};

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and outputs
  always_comb begin
    state_d             = state_q;
    icache_read_ready_o = 1'b0;
    mem_req_valid_o     = 1'b0;
    miss_start          = 1'b0;
    beat_we             = 1'b0;
    line_done           = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A flush cycle never reports a hit and never starts a refill.
        if (!flush_i && icache_read_valid_i) begin
          if (hit) begin
            icache_read_ready_o = 1'b1;
          end else begin
            miss_start = 1'b1;
            state_d    = REQ;
          end
        end
      end
      REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) begin
          state_d = REFILL;
        end
      end
      REFILL: begin
        if (mem_resp_valid_i) begin
          beat_we = 1'b1;
          if (cnt_q == OFF_W'(WORDS_PER_LINE - 1)) begin
            line_done = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control: miss address, beat counter, flush tracking, valid bits
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      miss_line_q <= '0;
      cnt_q       <= '0;
      flushed_q   <= 1'b0;
      valid_q     <= '0;
    end else begin
      if (miss_start) begin
        miss_line_q <= icache_read_address_i[31:OFF_W+2];
      end

      if (state_q == REQ && mem_req_ready_i) begin
        cnt_q <= '0;
      end else if (beat_we) begin
        cnt_q <= cnt_q + OFF_W'(1);
      end

      // A flush seen at any point of a refill keeps the refilled line invalid.
      if (miss_start) begin
        flushed_q <= 1'b0;
      end else if (flush_i && state_q != IDLE) begin
        flushed_q <= 1'b1;
      end

      if (flush_i) begin
        valid_q <= '0;
      end else if (miss_start) begin
        // The victim line is overwritten beat by beat, so retire it up front.
        valid_q[icache_read_address_i[OFF_W+IDX_W+1:OFF_W+2]] <= 1'b0;
      end else if (line_done && !flushed_q) begin
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  // Data and tag arrays: no reset
  always_ff @(posedge clk_i) begin
    if (beat_we) begin
      data_q[{fill_idx, cnt_q}] <= mem_resp_data_i;
    end
    if (line_done) begin
      tag_q[fill_idx] <= fill_tag;
    end
  end

`ifdef ICACHE_PERF_COUNTERS_EN
  // Performance counters: free-running, wrap at 2^32, untouched by flush
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_count_o  <= '0;
      miss_count_o <= '0;
    end else begin
      if (icache_read_ready_o) begin
        hit_count_o <= hit_count_o + 32'd1;
      end
      if (miss_start) begin
        miss_count_o <= miss_count_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_responder.sv
// ---------------------------------------------------------------------------
// tb_icache_responder
//
// Bench for icache_responder (LINES=16, WORDS_PER_LINE=4). A memory model
// answers refill requests with data derived from the word address; every
// fetch pushes its expected word into a queue that is popped when the DUT
// raises ready.
// ---------------------------------------------------------------------------
module tb_icache_responder;

  localparam int WPL = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] icache_read_address_i;
  logic        icache_read_valid_i;
  logic [31:0] icache_read_data_o;
  logic        icache_read_ready_o;
  logic        flush_i;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [31:0] mem_req_address_o;
  logic        mem_resp_valid_i;
  logic [31:0] mem_resp_data_i;
`ifdef ICACHE_PERF_COUNTERS_EN
  logic [31:0] hit_count_o;
  logic [31:0] miss_count_o;
`endif

  icache_responder #(.LINES(16), .WORDS_PER_LINE(WPL)) dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .icache_read_address_i (icache_read_address_i),
    .icache_read_valid_i   (icache_read_valid_i),
    .icache_read_data_o    (icache_read_data_o),
    .icache_read_ready_o   (icache_read_ready_o),
    .flush_i               (flush_i),
    .mem_req_valid_o       (mem_req_valid_o),
    .mem_req_ready_i       (mem_req_ready_i),
    .mem_req_address_o     (mem_req_address_o),
    .mem_resp_valid_i      (mem_resp_valid_i),
`ifdef ICACHE_PERF_COUNTERS_EN
    .hit_count_o           (hit_count_o),
    .miss_count_o          (miss_count_o),
`endif
    .mem_resp_data_i       (mem_resp_data_i)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] req_log[$];
  int          beats_sent    = 0;
  int          addr_unstable = 0;
  int          early_ready   = 0;
  int          req_stall     = 0;
  int          beat_gap      = 0;

  // Word at a byte address: 0x8000_0000.. gives 0x00000013, 0x00100093, ...
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [11:0] w;
    w = a[13:2];
    return ({20'd0, w} << 20) | ({27'd0, w[4:0]} << 7) | 32'h13;
  endfunction

  // Memory model
  initial begin : memory_model
    logic [31:0] la;
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b0;
    mem_resp_data_i  = '0;
    forever begin
      @(posedge clk_i); #1;
      if (rst_ni && mem_req_valid_o) begin
        la = mem_req_address_o;
        for (int s = 0; s < req_stall; s++) begin
          @(posedge clk_i); #1;
          if (!mem_req_valid_o || mem_req_address_o !== la) addr_unstable++;
        end
        mem_req_ready_i = 1'b1;
        req_log.push_back(la);
        @(posedge clk_i); #1;
        mem_req_ready_i = 1'b0;
        for (int b = 0; b < WPL; b++) begin
          for (int g = 0; g < beat_gap; g++) begin
            @(posedge clk_i); #1;
            if (icache_read_ready_o) early_ready++;
          end
          mem_resp_valid_i = 1'b1;
          mem_resp_data_i  = mem_word(la + 32'(4 * b));
          @(posedge clk_i); #1;
          mem_resp_valid_i = 1'b0;
          beats_sent++;
          if (!rst_ni) break;
        end
      end
    end
  end

  // Drive one fetch and wait (bounded) for the DUT to answer it.
  task automatic fetch(input logic [31:0] a, output int cycles);
    logic [31:0] e;
    icache_read_address_i = a;
    icache_read_valid_i   = 1'b1;
    exp_q.push_back(mem_word(a));
    cycles = 0;
    forever begin
      @(negedge clk_i);
      if (icache_read_ready_o) begin
        e = exp_q.pop_front();
        total++;
        if (icache_read_data_o !== e) begin
          bad++;
          $display("FAIL fetch_data addr=%h got=%h want=%h", a, icache_read_data_o, e);
        end
        break;
      end
      cycles++;
      if (cycles > 200) begin
        e = exp_q.pop_front();
        total++; bad++;
        $display("FAIL fetch_timeout addr=%h got=no_ready want=%h", a, e);
        break;
      end
    end
    @(posedge clk_i); #1;
  endtask

  task automatic idle();
    icache_read_valid_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; flush_i = 1'b0;
    icache_read_valid_i = 1'b0; icache_read_address_i = 32'h8000_0000;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    total++;
    if (icache_read_ready_o !== 1'b0 || mem_req_valid_o !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b%b want=00", icache_read_ready_o, mem_req_valid_o);
    end
    total++;
    if (mem_req_address_o !== 32'h0) begin
      bad++; $display("FAIL reset_addr got=%h want=0", mem_req_address_o);
    end
    total++;
    if (icache_read_data_o !== 32'h0) begin
      bad++; $display("FAIL reset_data got=%h want=0", icache_read_data_o);
    end
`ifdef ICACHE_PERF_COUNTERS_EN
    total++;
    if (hit_count_o !== 32'd0 || miss_count_o !== 32'd0) begin
      bad++; $display("FAIL reset_counters got=%0d/%0d want=0/0", hit_count_o, miss_count_o);
    end
`endif
  endtask

  task automatic test_cold_miss();
    int c, r0, b0;
    r0 = req_log.size(); b0 = beats_sent;
    fetch(32'h8000_0000, c);
    total++;
    if (req_log.size() != r0 + 1 || req_log[$] !== 32'h8000_0000) begin
      bad++; $display("FAIL cold_req got=%0d reqs want=1 at 80000000", req_log.size() - r0);
    end
    total++;
    if (beats_sent - b0 != 4 || c < 5) begin
      bad++; $display("FAIL cold_beats got=%0d beats/%0d cyc want=4 beats/>=5 cyc", beats_sent - b0, c);
    end
`ifdef ICACHE_PERF_COUNTERS_EN
    total++;
    if (miss_count_o !== 32'd1) begin
      bad++; $display("FAIL cold_miss_count got=%0d want=1", miss_count_o);
    end
`endif
  endtask

  task automatic test_same_line_hits();
    int c, r0;
    logic [31:0] addrs [3];
    addrs[0] = 32'h8000_0004; addrs[1] = 32'h8000_0008; addrs[2] = 32'h8000_000C;
    r0 = req_log.size();
    for (int i = 0; i < 3; i++) begin
      fetch(addrs[i], c);
      total++;
      if (c != 0) begin
        bad++; $display("FAIL hit_latency addr=%h got=%0d want=0", addrs[i], c);
      end
    end
    idle();
    total++;
    if (req_log.size() != r0) begin
      bad++; $display("FAIL hit_no_req got=%0d want=0", req_log.size() - r0);
    end
  endtask

  task automatic test_conflict();
    int c, r0;
    r0 = req_log.size();
    fetch(32'h8000_0100, c);
    fetch(32'h8000_0000, c);
    idle();
    total++;
    if (req_log.size() != r0 + 2) begin
      bad++; $display("FAIL conflict_count got=%0d want=2", req_log.size() - r0);
    end else begin
      total++;
      if (req_log[r0] !== 32'h8000_0100 || req_log[r0+1] !== 32'h8000_0000) begin
        bad++; $display("FAIL conflict_order got=%h,%h want=80000100,80000000", req_log[r0], req_log[r0+1]);
      end
    end
  endtask

  task automatic test_stalled();
    int c, r0, b0;
    r0 = req_log.size(); b0 = beats_sent;
    addr_unstable = 0; early_ready = 0;
    req_stall = 5; beat_gap = 2;
    fetch(32'h8000_0208, c);
    idle();
    req_stall = 0; beat_gap = 0;
    total++;
    if (addr_unstable != 0 || early_ready != 0) begin
      bad++; $display("FAIL stall_stable got=%0d/%0d want=0/0", addr_unstable, early_ready);
    end
    total++;
    if (beats_sent - b0 != 4 || req_log.size() != r0 + 1 || req_log[$] !== 32'h8000_0200) begin
      bad++; $display("FAIL stall_refill got=%0d beats %0d reqs want=4 beats 1 req", beats_sent - b0, req_log.size() - r0);
    end
  endtask

  task automatic test_flush_refill();
    int c, r0, g;
    fetch(32'h8000_0000, c);
    fetch(32'h8000_0000, c);
    total++;
    if (c != 0) begin
      bad++; $display("FAIL flush_prime got=%0d want=0", c);
    end
    idle();
    r0 = req_log.size();
    fork
      fetch(32'h8000_0040, c);
      begin
        int b0;
        b0 = beats_sent; g = 0;
        while (beats_sent != b0 + 1 && g < 2000) begin #1; g++; end
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
      end
    join
    idle();
    total++;
    if (req_log.size() != r0 + 2) begin
      bad++; $display("FAIL flush_refetch got=%0d reqs want=2", req_log.size() - r0);
    end
    r0 = req_log.size();
    fetch(32'h8000_0000, c);
    idle();
    total++;
    if (req_log.size() != r0 + 1) begin
      bad++; $display("FAIL flush_other got=%0d reqs want=1", req_log.size() - r0);
    end
  endtask

  task automatic test_flush_idle();
    int c, r0;
    fetch(32'h8000_0004, c);
    total++;
    if (c != 0) begin
      bad++; $display("FAIL flush_idle_prime got=%0d want=0", c);
    end
    icache_read_address_i = 32'h8000_0004;
    flush_i = 1'b1;
    @(negedge clk_i);
    total++;
    if (icache_read_ready_o !== 1'b0 || mem_req_valid_o !== 1'b0) begin
      bad++; $display("FAIL flush_idle_ready got=%b want=0", icache_read_ready_o);
    end
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    r0 = req_log.size();
    fetch(32'h8000_0004, c);
    idle();
    total++;
    if (req_log.size() != r0 + 1) begin
      bad++; $display("FAIL flush_idle_miss got=%0d reqs want=1", req_log.size() - r0);
    end
  endtask

  task automatic test_async_reset();
    int c, r0, b0, g;
    b0 = beats_sent;
    icache_read_address_i = 32'h8000_0080;
    icache_read_valid_i   = 1'b1;
    g = 0;
    while (beats_sent != b0 + 1 && g < 2000) begin #1; g++; end
    rst_ni = 1'b0;
    #1;
    total++;
    if (mem_req_valid_o !== 1'b0 || icache_read_ready_o !== 1'b0) begin
      bad++; $display("FAIL areset_outputs got=%b%b want=00", mem_req_valid_o, icache_read_ready_o);
    end
`ifdef ICACHE_PERF_COUNTERS_EN
    total++;
    if (hit_count_o !== 32'd0 || miss_count_o !== 32'd0) begin
      bad++; $display("FAIL areset_counters got=%0d/%0d want=0/0", hit_count_o, miss_count_o);
    end
`endif
    icache_read_valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    r0 = req_log.size();
    fetch(32'h8000_0080, c);
    idle();
    total++;
    if (req_log.size() != r0 + 1 || req_log[$] !== 32'h8000_0080) begin
      bad++; $display("FAIL areset_fresh got=%0d reqs want=1 at 80000080", req_log.size() - r0);
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_same_line_hits();
    test_conflict();
    test_stalled();
    test_flush_refill();
    test_flush_idle();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
